// File: rtl/bus_pkt_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | bus_pkt_dispatch_pkg : shared modes and width helpers  rev 1.0 |
// +----------------------------------------------------------------+
package bus_pkt_dispatch_pkg;

  localparam int MODE_RR   = 0;
  localparam int MODE_SKIP = 1;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 2) ? $clog2(num_ch) : 1;
  endfunction

  // Wide enough to hold PKT_BEATS itself, not only PKT_BEATS-1.
  function automatic int beat_cnt_width(input int pkt_beats);
    return $clog2(pkt_beats + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_pkt_dispatch_rr.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_next_ready : circular first-ready search from start  rev 1.0 |
// +----------------------------------------------------------------+
module rr_next_ready
  import bus_pkt_dispatch_pkg::*;
#(
  parameter  int NUM_CH = 16,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] ready,
  input  logic [CH_W-1:0]   start,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [CH_W:0] cand;

  // Scan from the farthest offset down so the nearest ready channel wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = {1'b0, start} + (CH_W + 1)'(i);
      if (cand >= (CH_W + 1)'(NUM_CH)) begin
        cand = cand - (CH_W + 1)'(NUM_CH);
      end
      if (ready[cand[CH_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[CH_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_pkt_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------+
// | bus_pkt_dispatch : round-robin packet steering to NUM_CH  rev 1.0 |
// +----------------------------------------------------------------+
module bus_pkt_dispatch
  import bus_pkt_dispatch_pkg::*;
#(
  parameter  int BUS         = 534,
  parameter  int NUM_CH      = 16,
  parameter  int PKT_BEATS   = 25,
  parameter  int MODE        = MODE_RR,
  parameter  int DATA_STAGES = 2,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk_bus,
  input  logic              rst,
  input  logic [BUS-1:0]    bus_data,
  input  logic              bus_en,
  output logic              bus_ready,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [BUS-1:0]    ch_data,
  output logic [NUM_CH-1:0] ch_en,
  output logic [CH_W-1:0]   cur_ch,
  output logic [15:0]       pkt_cnt,
  output logic              err
);

  localparam int               CNT_W     = beat_cnt_width(PKT_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_BEATS - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]  cur_ch_q,    cur_ch_d;
  logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
  logic             bus_ready_q, bus_ready_d;
  logic [15:0]      pkt_cnt_q,   pkt_cnt_d;
  logic             err_q,       err_d;

  logic [CH_W-1:0]  ch_inc;
  logic             last_beat;
  logic             nxt_found;
  logic [CH_W-1:0]  nxt_idx;

  assign ch_inc = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + CH_W'(1);

  rr_next_ready #(
    .NUM_CH (NUM_CH)
  ) u_rr (
    .ready (ch_ready),
    .start (ch_inc),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  always_comb begin
    cur_ch_d   = cur_ch_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    last_beat  = bus_en && (beat_cnt_q == LAST_BEAT);

    if (bus_en) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
    end

    if (last_beat) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
      cur_ch_d  = (MODE == MODE_SKIP && nxt_found) ? nxt_idx : ch_inc;
    end else if (MODE == MODE_SKIP && beat_cnt_q == '0 && !bus_en &&
                 !ch_ready[cur_ch_q] && nxt_found) begin
      cur_ch_d = nxt_idx;
    end

    // Ready follows the channel being loaded, so a hop or advance is
    // reflected upstream on the very next cycle.
    bus_ready_d = ch_ready[cur_ch_d];
    err_d       = err_q | (bus_en & ~bus_ready_q);
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      cur_ch_q    <= '0;
      beat_cnt_q  <= '0;
      bus_ready_q <= 1'b0;
      pkt_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      cur_ch_q    <= cur_ch_d;
      beat_cnt_q  <= beat_cnt_d;
      bus_ready_q <= bus_ready_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
    end
  end

  genvar s;
  generate
    for (s = 0; s < DATA_STAGES; s++) begin : g_stage
      logic [BUS-1:0]  in_data;
      logic            in_en;
      logic [CH_W-1:0] in_ch;
      logic [BUS-1:0]  data_q, data_d;
      logic            en_q,   en_d;
      logic [CH_W-1:0] ch_q,   ch_d;

      if (s == 0) begin : g_head
        assign in_data = bus_data;
        assign in_en   = bus_en;
        assign in_ch   = cur_ch_q;
      end else begin : g_tail
        assign in_data = g_stage[s-1].data_q;
        assign in_en   = g_stage[s-1].en_q;
        assign in_ch   = g_stage[s-1].ch_q;
      end

      always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        en_d   = in_en;
        if (in_en) begin
          data_d = in_data;
          ch_d   = in_ch;
        end
      end

      always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
          data_q <= '0;
          en_q   <= 1'b0;
          ch_q   <= '0;
        end else begin
          data_q <= data_d;
          en_q   <= en_d;
          ch_q   <= ch_d;
        end
      end
    end
  endgenerate

  always_comb begin
    ch_en = '0;
    ch_en[g_stage[DATA_STAGES-1].ch_q] = g_stage[DATA_STAGES-1].en_q;
  end

  assign ch_data   = g_stage[DATA_STAGES-1].data_q;
  assign bus_ready = bus_ready_q;
  assign cur_ch    = cur_ch_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_pkt_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_bus_pkt_dispatch : scoreboard bench, two configs     rev 1.0 |
// +----------------------------------------------------------------+
module tb_bus_pkt_dispatch;

  localparam int BUS = 534;
  localparam int N0 = 4, M0 = 1, PB0 = 3, DS0 = 2;
  localparam int N1 = 5, M1 = 0, PB1 = 1, DS1 = 3;
  localparam int NCH [2] = '{N0, N1};
  localparam int MOD [2] = '{M0, M1};
  localparam int PB  [2] = '{PB0, PB1};
  localparam int DS  [2] = '{DS0, DS1};

  typedef struct {
    int             due;
    int             ch;
    logic [BUS-1:0] data;
  } exp_t;

  logic           clk_bus = 1'b0;
  logic           rst;
  logic [BUS-1:0] bus_data;
  logic           bus_en;
  logic [N0-1:0]  ch_ready0;
  logic [N1-1:0]  ch_ready1;

  logic           bus_ready0, bus_ready1;
  logic [BUS-1:0] ch_data0, ch_data1;
  logic [N0-1:0]  ch_en0;
  logic [N1-1:0]  ch_en1;
  logic [1:0]     cur_ch0;
  logic [2:0]     cur_ch1;
  logic [15:0]    pkt_cnt0, pkt_cnt1;
  logic           err0, err1;

  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  int   m_cur [2];
  int   m_cnt [2];
  int   m_pkt [2];
  bit   m_rdy [2];
  bit   m_err [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk_bus = ~clk_bus;

  bus_pkt_dispatch #(
    .BUS(BUS), .NUM_CH(N0), .PKT_BEATS(PB0), .MODE(M0), .DATA_STAGES(DS0)
  ) u_dut0 (
    .clk_bus(clk_bus), .rst(rst), .bus_data(bus_data), .bus_en(bus_en),
    .bus_ready(bus_ready0), .ch_ready(ch_ready0), .ch_data(ch_data0),
    .ch_en(ch_en0), .cur_ch(cur_ch0), .pkt_cnt(pkt_cnt0), .err(err0)
  );

  bus_pkt_dispatch #(
    .BUS(BUS), .NUM_CH(N1), .PKT_BEATS(PB1), .MODE(M1), .DATA_STAGES(DS1)
  ) u_dut1 (
    .clk_bus(clk_bus), .rst(rst), .bus_data(bus_data), .bus_en(bus_en),
    .bus_ready(bus_ready1), .ch_ready(ch_ready1), .ch_data(ch_data1),
    .ch_en(ch_en1), .cur_ch(cur_ch1), .pkt_cnt(pkt_cnt1), .err(err1)
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at edge %0d", name, d, act, exp, edge_n);
    end
  endtask

  // Reference: channel choice from the rotation rules, expressed as plain
  // modular search over the ready vector.
  task automatic model_step(input int d, input logic en, input logic [BUS-1:0] dat, input logic [7:0] rdy);
    int   n, nxt, sel, c;
    bit   found, last;
    exp_t e;
    n = NCH[d];
    found = 0;
    sel = 0;
    for (int k = 1; k <= n; k++) begin
      c = (m_cur[d] + k) % n;
      if (!found && rdy[c]) begin
        found = 1;
        sel = c;
      end
    end
    last = en && (m_cnt[d] == PB[d] - 1);
    nxt = m_cur[d];
    if (en) begin
      e.due = edge_n + DS[d] - 1;
      e.ch = m_cur[d];
      e.data = dat;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      if (!m_rdy[d]) m_err[d] = 1;
      m_cnt[d] = last ? 0 : m_cnt[d] + 1;
    end
    if (last) begin
      nxt = (MOD[d] == 1 && found) ? sel : (m_cur[d] + 1) % n;
      m_pkt[d] = (m_pkt[d] + 1) % 65536;
    end else if (MOD[d] == 1 && m_cnt[d] == 0 && !en && !rdy[m_cur[d]] && found) begin
      nxt = sel;
    end
    m_cur[d] = nxt;
    m_rdy[d] = rdy[nxt];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = 0;
      m_cnt[d] = 0;
      m_pkt[d] = 0;
      m_rdy[d] = 0;
      m_err[d] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge();
    edge_n++;
    model_step(0, bus_en, bus_data, {4'b0, ch_ready0});
    model_step(1, bus_en, bus_data, {3'b0, ch_ready1});
  endtask

  always @(posedge clk_bus or posedge rst) begin
    if (rst) model_reset();
    else model_edge();
  end

  task automatic check_dut(input int d, input logic [7:0] en_v, input logic [BUS-1:0] dat,
                           input int cur, input logic br, input logic er, input int pkt);
    exp_t e;
    bit   have;
    chk("cur_ch", d, cur, m_cur[d]);
    chk("bus_ready", d, 32'(br), 32'(m_rdy[d]));
    chk("err", d, 32'(er), 32'(m_err[d]));
    chk("pkt_cnt", d, pkt, m_pkt[d]);
    have = 0;
    if (d == 0 && q0.size() > 0 && q0[0].due == edge_n) begin
      e = q0.pop_front();
      have = 1;
    end
    if (d == 1 && q1.size() > 0 && q1[0].due == edge_n) begin
      e = q1.pop_front();
      have = 1;
    end
    if (have) begin
      chk("ch_en", d, 32'(en_v), 32'(1) << e.ch);
      total++;
      if (dat !== e.data) begin
        bad++;
        $display("FAIL ch_data dut%0d actual=%0h required=%0h", d, dat, e.data);
      end
    end else begin
      chk("ch_en_idle", d, 32'(en_v), 32'd0);
    end
  endtask

  task automatic monitor_cycle();
    check_dut(0, {4'b0, ch_en0}, ch_data0, int'(cur_ch0), bus_ready0, err0, int'(pkt_cnt0));
    check_dut(1, {3'b0, ch_en1}, ch_data1, int'(cur_ch1), bus_ready1, err1, int'(pkt_cnt1));
  endtask

  always @(negedge clk_bus) begin
    if (!rst) monitor_cycle();
  end

  task automatic reset_checks();
    chk("rst_cur_ch", 0, 32'(cur_ch0), 0);
    chk("rst_bus_ready", 0, 32'(bus_ready0), 0);
    chk("rst_ch_en", 0, 32'(ch_en0), 0);
    chk("rst_ch_data", 0, 32'(|ch_data0), 0);
    chk("rst_pkt_cnt", 0, 32'(pkt_cnt0), 0);
    chk("rst_err", 0, 32'(err0), 0);
    chk("rst_cur_ch", 1, 32'(cur_ch1), 0);
    chk("rst_bus_ready", 1, 32'(bus_ready1), 0);
    chk("rst_ch_en", 1, 32'(ch_en1), 0);
    chk("rst_ch_data", 1, 32'(|ch_data1), 0);
    chk("rst_pkt_cnt", 1, 32'(pkt_cnt1), 0);
    chk("rst_err", 1, 32'(err1), 0);
  endtask

  task automatic drive(input logic en, input logic [N0-1:0] r0, input logic [N1-1:0] r1);
    logic [543:0] tmp;
    for (int k = 0; k < 17; k++) tmp[k*32 +: 32] = $urandom;
    bus_en = en;
    bus_data = tmp[BUS-1:0];
    ch_ready0 = r0;
    ch_ready1 = r1;
    @(posedge clk_bus);
    #1;
  endtask

  initial begin
    bit wrapped;
    wrapped = 0;
    rst = 1'b1;
    bus_en = 1'b0;
    bus_data = '0;
    ch_ready0 = '1;
    ch_ready1 = '1;
    repeat (3) @(posedge clk_bus);
    #1;
    reset_checks();
    rst = 1'b0;

    // Strict/rotating flow with everything ready, then skip and hop cases.
    drive(1'b0, 4'hF, 5'h1F);
    repeat (12) drive(1'b1, 4'hF, 5'h1F);
    repeat (4) drive(1'b0, 4'hF, 5'h1F);
    repeat (9) drive(1'b1, 4'b1011, 5'h1F);
    repeat (4) drive(1'b0, 4'b1011, 5'h1F);
    repeat (2) drive(1'b0, 4'b0100, 5'h1F);

    // Beats into a channel that is not ready.
    repeat (2) drive(1'b0, 4'b0000, 5'h1F);
    repeat (3) drive(1'b1, 4'b0000, 5'h1F);
    repeat (4) drive(1'b0, 4'hF, 5'h1F);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
    end
    repeat (6) drive(1'b0, 4'hF, 5'h1F);

    // Reset in the middle of a packet with a beat still in the pipeline.
    drive(1'b1, 4'hF, 5'h1F);
    bus_en = 1'b0;
    rst = 1'b1;
    #1;
    reset_checks();
    @(posedge clk_bus);
    #1;
    rst = 1'b0;
    drive(1'b0, 4'hF, 5'h1F);
    repeat (3) drive(1'b1, 4'hF, 5'h1F);
    repeat (4) drive(1'b0, 4'hF, 5'h1F);

    // Single-beat packets on the five-channel instance walk pkt_cnt round.
    for (int i = 0; i < 70000 && !wrapped; i++) begin
      drive(1'b1, 4'hF, 5'h1F);
      if (m_pkt[1] == 0) wrapped = 1;
    end
    chk("pkt_wrap_seen", 1, 32'(wrapped), 1);
    chk("pkt_wrap_value", 1, 32'(pkt_cnt1), 0);
    repeat (6) drive(1'b0, 4'hF, 5'h1F);
    chk("queue_drained", 0, 32'(q0.size() + q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
